// File: rtl/gsu_mem_arbiter.sv
// SRAM0 arbiter: SNES bus cycles (priority) versus GSU fetches/stores, fixed-length registered strobes.
// Optional: define GSU_SAVERAM_WP_EN to block GSU writes outside the save-RAM region.
module gsu_mem_arbiter #(
   parameter int unsigned ACCESS_CYCLES = 4,
   parameter logic [3:0]  SAVERAM_BASE  = 4'hE
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        SNES_REQ,
   input  logic        SNES_WE,
   input  logic [23:0] SNES_ADDR_IN,
   input  logic [7:0]  SNES_WDATA,
   output logic [7:0]  SNES_RDATA,
   output logic        SNES_ACK,
   output logic        SNES_OVERRUN,
   input  logic        GSU_REQ,
   input  logic        GSU_WE,
   input  logic [23:0] GSU_ADDR,
   input  logic [7:0]  GSU_WDATA,
   output logic [7:0]  GSU_RDATA,
   output logic        GSU_ACK,
   output logic [23:0] RAM_ADDR,
   output logic [7:0]  RAM_DOUT,
   input  logic [7:0]  RAM_DIN,
   output logic        RAM_DRIVE,
   output logic        RAM_OE_N,
   output logic        RAM_WE_N
);

   localparam int unsigned    CW       = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(ACCESS_CYCLES - 1);
   localparam logic [CW-1:0]  WE_LAST  = CW'(ACCESS_CYCLES - 2);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
`ifdef GSU_SAVERAM_WP_EN
   localparam logic WP_EN = 1'b1;
`else
   localparam logic WP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SNES_ACC = 2'd1,
      ST_GSU_ACC  = 2'd2,
      ST_RECOVER  = 2'd3
   } state_t;

   function automatic logic outside_saveram(input logic [3:0] region);
      return region != SAVERAM_BASE;
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_v_q, pend_v_d;
   logic          pend_we_q, pend_we_d;
   logic [23:0]   pend_addr_q, pend_addr_d;
   logic [7:0]    pend_wdata_q, pend_wdata_d;
   logic          ovr_q, ovr_d;
   logic          acc_snes_q, acc_snes_d;
   logic          acc_we_q, acc_we_d;
   logic          acc_wp_q, acc_wp_d;
   logic [23:0]   ram_addr_q, ram_addr_d;
   logic [7:0]    ram_dout_q, ram_dout_d;
   logic          ram_drive_q, ram_drive_d;
   logic          ram_oe_n_q, ram_oe_n_d;
   logic          ram_we_n_q, ram_we_n_d;
   logic [7:0]    snes_rdata_q, snes_rdata_d;
   logic [7:0]    gsu_rdata_q, gsu_rdata_d;
   logic          snes_ack_q, snes_ack_d;
   logic          gsu_ack_q, gsu_ack_d;
   logic          access_d;

   // Next-state, pending-request capture and strobe decode for the following cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pend_v_d     = pend_v_q;
      pend_we_d    = pend_we_q;
      pend_addr_d  = pend_addr_q;
      pend_wdata_d = pend_wdata_q;
      ovr_d        = ovr_q;
      acc_snes_d   = acc_snes_q;
      acc_we_d     = acc_we_q;
      acc_wp_d     = acc_wp_q;
      ram_addr_d   = ram_addr_q;
      ram_dout_d   = ram_dout_q;
      snes_rdata_d = snes_rdata_q;
      gsu_rdata_d  = gsu_rdata_q;
      snes_ack_d   = 1'b0;
      gsu_ack_d    = 1'b0;

      if (SNES_REQ) begin
         pend_v_d     = 1'b1;
         pend_we_d    = SNES_WE;
         pend_addr_d  = SNES_ADDR_IN;
         pend_wdata_d = SNES_WDATA;
         if (pend_v_q) begin
            ovr_d = 1'b1;
         end else begin
            ovr_d = ovr_q;
         end
      end else begin
         pend_v_d = pend_v_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (SNES_REQ || pend_v_q) begin
               // A request sampled this edge is newer than anything already pending.
               state_d    = ST_SNES_ACC;
               cnt_d      = '0;
               acc_snes_d = 1'b1;
               acc_wp_d   = 1'b0;
               acc_we_d   = SNES_REQ ? SNES_WE      : pend_we_q;
               ram_addr_d = SNES_REQ ? SNES_ADDR_IN : pend_addr_q;
               ram_dout_d = SNES_REQ ? SNES_WDATA   : pend_wdata_q;
               pend_v_d   = 1'b0;
            end else if (GSU_REQ) begin
               state_d    = ST_GSU_ACC;
               cnt_d      = '0;
               acc_snes_d = 1'b0;
               acc_we_d   = GSU_WE;
               acc_wp_d   = WP_EN && GSU_WE && outside_saveram(GSU_ADDR[23:20]);
               ram_addr_d = GSU_ADDR;
               ram_dout_d = GSU_WDATA;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SNES_ACC, ST_GSU_ACC: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RECOVER;
               cnt_d   = '0;
               if (!acc_we_q && acc_snes_q) begin
                  snes_rdata_d = RAM_DIN;
               end else if (!acc_we_q) begin
                  gsu_rdata_d = RAM_DIN;
               end else begin
                  snes_rdata_d = snes_rdata_q;
               end
               snes_ack_d = acc_snes_q;
               gsu_ack_d  = !acc_snes_q;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_RECOVER: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      access_d    = (state_d == ST_SNES_ACC) || (state_d == ST_GSU_ACC);
      ram_oe_n_d  = !(access_d && !acc_we_d);
      ram_drive_d = access_d && acc_we_d && !acc_wp_d;
      ram_we_n_d  = !(ram_drive_d && (cnt_d >= CNT_ONE) && (cnt_d <= WE_LAST));
   end

   // State and output registers; reset drops any in-flight access without an ACK.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         pend_v_q     <= 1'b0;
         pend_we_q    <= 1'b0;
         pend_addr_q  <= 24'h000000;
         pend_wdata_q <= 8'h00;
         ovr_q        <= 1'b0;
         acc_snes_q   <= 1'b0;
         acc_we_q     <= 1'b0;
         acc_wp_q     <= 1'b0;
         ram_addr_q   <= 24'h000000;
         ram_dout_q   <= 8'h00;
         ram_drive_q  <= 1'b0;
         ram_oe_n_q   <= 1'b1;
         ram_we_n_q   <= 1'b1;
         snes_rdata_q <= 8'h00;
         gsu_rdata_q  <= 8'h00;
         snes_ack_q   <= 1'b0;
         gsu_ack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pend_v_q     <= pend_v_d;
         pend_we_q    <= pend_we_d;
         pend_addr_q  <= pend_addr_d;
         pend_wdata_q <= pend_wdata_d;
         ovr_q        <= ovr_d;
         acc_snes_q   <= acc_snes_d;
         acc_we_q     <= acc_we_d;
         acc_wp_q     <= acc_wp_d;
         ram_addr_q   <= ram_addr_d;
         ram_dout_q   <= ram_dout_d;
         ram_drive_q  <= ram_drive_d;
         ram_oe_n_q   <= ram_oe_n_d;
         ram_we_n_q   <= ram_we_n_d;
         snes_rdata_q <= snes_rdata_d;
         gsu_rdata_q  <= gsu_rdata_d;
         snes_ack_q   <= snes_ack_d;
         gsu_ack_q    <= gsu_ack_d;
      end
   end

   assign SNES_RDATA   = snes_rdata_q;
   assign SNES_ACK     = snes_ack_q;
   assign SNES_OVERRUN = ovr_q;
   assign GSU_RDATA    = gsu_rdata_q;
   assign GSU_ACK      = gsu_ack_q;
   assign RAM_ADDR     = ram_addr_q;
   assign RAM_DOUT     = ram_dout_q;
   assign RAM_DRIVE    = ram_drive_q;
   assign RAM_OE_N     = ram_oe_n_q;
   assign RAM_WE_N     = ram_we_n_q;

endmodule
